key_event_detect: RTL

- Classifies one debounced key line into discrete user events: press, release, short click, double click, long press and auto-repeat.
- Sits directly downstream of the key debouncer. Its input idles high; the key is active-low by default.
- All timing is measured in ticks of an external strobe (e.g. 1 ms), so the block is clock-frequency independent.
- Outputs are single-cycle pulses for the control/register logic, plus one hold level.

---
 rtl/key_evt_pkg.sv | 27 ++
 rtl/key_edge_det.sv | 26 ++
 rtl/key_event_detect.sv | 127 ++++++++++++
 3 files changed

// File: rtl/key_evt_pkg.sv
// Shared types for the key event classifier: FSM states and bit positions of
// each event pulse when packed into a downstream status/interrupt word.
package key_evt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_e;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_SHORT   = 2;
  localparam int EV_DOUBLE  = 3;
  localparam int EV_LONG    = 4;
  localparam int EV_REPEAT  = 5;
  localparam int EV_NUM     = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Normalises the key polarity and flags press/release edges, combinationally on the current level.
// History resets to "pressed" so a key held through reset must be released before it can press.
module key_edge_det #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_pe,
  output logic o_re
);

  logic w_lvl;
  logic r_kq;

  assign w_lvl = i_key ^ ACTIVE_LOW;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_kq <= 1'b1;
    else       r_kq <= w_lvl;
  end

  assign o_pe = w_lvl & ~r_kq;
  assign o_re = ~w_lvl & r_kq;

endmodule

// File: rtl/key_event_detect.sv
// Classifies a debounced key into press/release/short/double/long/repeat pulses plus a hold level.
// All outputs registered (one cycle after the sampling edge); timing counted in tick_i strobes.
module key_event_detect
  import key_evt_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int CNT_W      = 12,
  parameter int LONG_TICKS = 1000,
  parameter int DBL_TICKS  = 250,
  parameter int RPT_TICKS  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic tick_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic double_o,
  output logic long_o,
  output logic repeat_o,
  output logic hold_o
);

  if (max3(LONG_TICKS, DBL_TICKS, RPT_TICKS) > int'((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_w
    $error("key_event_detect: CNT_W too narrow for the tick thresholds");
  end
  if (LONG_TICKS < 1 || DBL_TICKS < 1 || RPT_TICKS < 1) begin : g_bad_ticks
    $error("key_event_detect: tick thresholds must be at least 1");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_TICKS - 1);

  key_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_pe, w_re;
  logic             w_press, w_release, w_short, w_double, w_long, w_repeat, w_wrap;
  logic             w_long_hit, w_dbl_hit, w_rpt_hit;

  key_edge_det #(.ACTIVE_LOW(ACTIVE_LOW)) u_edge (
    .i_clk (clk),
    .i_rst (rst),
    .i_key (key_i),
    .o_pe  (w_pe),
    .o_re  (w_re)
  );

  assign w_long_hit = tick_i && (r_cnt == LONG_LAST);
  assign w_dbl_hit  = tick_i && (r_cnt == DBL_LAST);
  assign w_rpt_hit  = tick_i && (r_cnt == RPT_LAST);

  // Edges are tested before thresholds so an edge always wins a same-cycle tie.
  always_comb begin
    w_next    = r_state;
    w_press   = 1'b0;
    w_release = 1'b0;
    w_short   = 1'b0;
    w_double  = 1'b0;
    w_long    = 1'b0;
    w_repeat  = 1'b0;
    w_wrap    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pe) begin w_next = PRESS1; w_press = 1'b1; end
      end
      PRESS1: begin
        if (w_re)            begin w_next = WAIT2; w_release = 1'b1; end
        else if (w_long_hit) begin w_next = LONG;  w_long    = 1'b1; end
      end
      WAIT2: begin
        if (w_pe)           begin w_next = PRESS2; w_press = 1'b1; end
        else if (w_dbl_hit) begin w_next = IDLE;   w_short = 1'b1; end
      end
      PRESS2: begin
        if (w_re) begin
          w_next    = IDLE;
          w_release = 1'b1;
          w_double  = 1'b1;
        end else if (w_long_hit) begin
          w_next = LONG;
          w_long = 1'b1;
        end
      end
      LONG: begin
        if (w_re)           begin w_next = IDLE;   w_release = 1'b1; end
        else if (w_rpt_hit) begin w_repeat = 1'b1; w_wrap    = 1'b1; end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_next != r_state || w_wrap)
      w_cnt_nxt = '0;
    else if (tick_i && !w_pe && !w_re && r_cnt != '1)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      short_o   <= 1'b0;
      double_o  <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      hold_o    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      press_o   <= w_press;
      release_o <= w_release;
      short_o   <= w_short;
      double_o  <= w_double;
      long_o    <= w_long;
      repeat_o  <= w_repeat;
      // Rises with long_o, and stays up through the release_o cycle.
      hold_o    <= (r_state == LONG) || (w_next == LONG);
    end
  end

endmodule
